// File: rtl/mod_clkgen_nphase.sv
`default_nettype none
// ============================================================================
//  Module   : mod_clkgen_nphase
//  Purpose  : N-phase modulation clock generator. A prescaler produces step
//             ticks; a step counter sweeps 2**PHASE_W steps per output period.
//             Each channel is high while its phase-shifted step lies in the
//             first half-period, excluding a leading dead-time window.
//             Configuration is double-buffered and only swapped at period
//             boundaries or on run entry, so outputs never produce runts.
//  Revision : 1.0  initial release
// ============================================================================
module mod_clkgen_nphase #(
    parameter int NUM_CH   = 3,
    parameter int DIV_W    = 16,
    parameter int PHASE_W  = 5,
    parameter int DEF_DIV  = 0,
    parameter int DEF_DEAD = 1
) (
    input  logic                        USER_CLOCK,
    input  logic                        RESET,
    input  logic                        ENABLE,
    input  logic                        CFG_VALID,
    output logic                        CFG_READY,
    input  logic [DIV_W-1:0]            CFG_DIV,
    input  logic [PHASE_W-1:0]          CFG_DEAD,
    input  logic [NUM_CH*PHASE_W-1:0]   CFG_OFFSET,
    output logic                        CFG_DONE,
    output logic                        SYNC_OUT,
    output logic [NUM_CH-1:0]           CLK_OUT
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [0:0]         S_IDLE      = 1'b0;
    localparam logic [0:0]         S_RUN       = 1'b1;
    localparam logic [PHASE_W-1:0] C_LAST_STEP = {PHASE_W{1'b1}};
    localparam logic [DIV_W-1:0]   C_DEF_DIV   = DIV_W'(DEF_DIV);
    localparam logic [PHASE_W-1:0] C_DEF_DEAD  = PHASE_W'(DEF_DEAD);

    // ------------------------------------------------------------------------
    // State, counters and configuration registers
    // ------------------------------------------------------------------------
    logic [0:0]                  state_q,     state_d;
    logic [DIV_W-1:0]            presc_q,     presc_d;
    logic [PHASE_W-1:0]          step_q,      step_d;

    logic [DIV_W-1:0]            act_div_q,   act_div_d;
    logic [PHASE_W-1:0]          act_dead_q,  act_dead_d;
    logic [NUM_CH*PHASE_W-1:0]   act_off_q,   act_off_d;

    logic                        pend_vld_q,  pend_vld_d;
    logic [DIV_W-1:0]            pend_div_q,  pend_div_d;
    logic [PHASE_W-1:0]          pend_dead_q, pend_dead_d;
    logic [NUM_CH*PHASE_W-1:0]   pend_off_q,  pend_off_d;

    logic [NUM_CH-1:0]           clk_out_q,   clk_out_d;
    logic                        sync_q,      sync_d;
    logic                        cfg_done_q,  cfg_done_d;

    // ------------------------------------------------------------------------
    // Combinational control wires
    // ------------------------------------------------------------------------
    logic                        w_run;       // FSM currently in RUN
    logic                        w_start;     // IDLE -> RUN this cycle
    logic                        w_tick;      // prescaler terminal count
    logic                        w_boundary;  // last tick of the period
    logic                        w_accept;    // new configuration captured
    logic                        w_apply;     // pending configuration activated
    logic                        w_dead_ok;   // dead time leaves a non-empty window
    logic [NUM_CH-1:0]           w_win;       // per-channel "inside high window"

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    // Holds the run/idle state; reset forces IDLE immediately.
    always_ff @(posedge USER_CLOCK) begin
        if (RESET) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    // Start immediately on ENABLE; stop only once the running period ends so
    // that a disable request never truncates an output pulse.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (ENABLE) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (w_boundary && !ENABLE) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: output decode
    // ------------------------------------------------------------------------
    // Derives the timing strobes that steer the datapath from the state.
    always_comb begin
        w_run      = (state_q == S_RUN);
        w_start    = (state_q == S_IDLE) && ENABLE;
        w_tick     = w_run && (presc_q == act_div_q);
        w_boundary = w_tick && (step_q == C_LAST_STEP);
    end

    // ------------------------------------------------------------------------
    // Prescaler and step counter
    // ------------------------------------------------------------------------
    // Prescaler counts 0..div and wraps on tick; step advances per tick and
    // wraps naturally at 2**PHASE_W. Both sit at zero whenever not running,
    // which also makes the first RUN cycle begin at step 0.
    always_comb begin
        presc_d = '0;
        step_d  = '0;
        if (w_run) begin
            if (w_tick) begin
                presc_d = '0;
                step_d  = step_q + PHASE_W'(1);
            end else begin
                presc_d = presc_q + DIV_W'(1);
                step_d  = step_q;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge USER_CLOCK) begin
        if (RESET) begin
            presc_q <= '0;
            step_q  <= '0;
        end else begin
            presc_q <= presc_d;
            step_q  <= step_d;
        end
    end

    // ------------------------------------------------------------------------
    // Configuration handshake and double buffering
    // ------------------------------------------------------------------------
    // A configuration is captured only when the pending slot is free. It is
    // activated at a period boundary or on run entry; an idle generator keeps
    // it pending. Accept and apply in one cycle would activate the older
    // pending value while the new one stays queued.
    always_comb begin
        w_accept    = CFG_VALID && !pend_vld_q;
        w_apply     = pend_vld_q && (w_boundary || w_start);

        pend_vld_d  = w_accept || (pend_vld_q && !w_apply);
        pend_div_d  = pend_div_q;
        pend_dead_d = pend_dead_q;
        pend_off_d  = pend_off_q;
        if (w_accept) begin
            pend_div_d  = CFG_DIV;
            pend_dead_d = CFG_DEAD;
            pend_off_d  = CFG_OFFSET;
        end

        act_div_d   = act_div_q;
        act_dead_d  = act_dead_q;
        act_off_d   = act_off_q;
        if (w_apply) begin
            act_div_d   = pend_div_q;
            act_dead_d  = pend_dead_q;
            act_off_d   = pend_off_q;
        end

        cfg_done_d  = w_apply;
    end

    // Configuration registers; reset restores the default timing and drops
    // anything still waiting in the pending slot.
    always_ff @(posedge USER_CLOCK) begin
        if (RESET) begin
            pend_vld_q  <= 1'b0;
            pend_div_q  <= '0;
            pend_dead_q <= '0;
            pend_off_q  <= '0;
            act_div_q   <= C_DEF_DIV;
            act_dead_q  <= C_DEF_DEAD;
            act_off_q   <= '0;
            cfg_done_q  <= 1'b0;
        end else begin
            pend_vld_q  <= pend_vld_d;
            pend_div_q  <= pend_div_d;
            pend_dead_q <= pend_dead_d;
            pend_off_q  <= pend_off_d;
            act_div_q   <= act_div_d;
            act_dead_q  <= act_dead_d;
            act_off_q   <= act_off_d;
            cfg_done_q  <= cfg_done_d;
        end
    end

    // ------------------------------------------------------------------------
    // Per-channel phase window
    // ------------------------------------------------------------------------
    // A dead time of half a period or more leaves no room for a high phase.
    assign w_dead_ok = !act_dead_q[PHASE_W-1];

    // rel = step - offset wraps modulo 2**PHASE_W. The channel is high for
    // dead <= rel < STEPS/2; the upper bound is simply rel's MSB being clear.
    // Channels half a period apart therefore cover disjoint windows, and any
    // dead time >= 1 inserts a gap at each hand-over.
    generate
        for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
            logic [PHASE_W-1:0] w_off;
            logic [PHASE_W-1:0] w_rel;

            assign w_off    = act_off_q[k*PHASE_W +: PHASE_W];
            assign w_rel    = step_q - w_off;
            assign w_win[k] = w_dead_ok
                              && (w_rel >= act_dead_q)
                              && !w_rel[PHASE_W-1];
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------------
    // Outputs follow the step counter by one cycle; idle forces them low and
    // the sync strobe marks the cycle after each period boundary.
    always_comb begin
        clk_out_d = w_run ? w_win : '0;
        sync_d    = w_boundary;
    end

    // Output flops; reset clears them on the very next edge.
    always_ff @(posedge USER_CLOCK) begin
        if (RESET) begin
            clk_out_q <= '0;
            sync_q    <= 1'b0;
        end else begin
            clk_out_q <= clk_out_d;
            sync_q    <= sync_d;
        end
    end

    assign CLK_OUT   = clk_out_q;
    assign SYNC_OUT  = sync_q;
    assign CFG_DONE  = cfg_done_q;
    assign CFG_READY = !pend_vld_q;

endmodule
`default_nettype wire

// File: tb/tb_mod_clkgen_nphase.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mod_clkgen_nphase
//  Purpose  : Directed self-checking bench for mod_clkgen_nphase with
//             NUM_CH=3, PHASE_W=5 (32 steps per period).
//  Revision : 1.0  initial release
// ============================================================================
module tb_mod_clkgen_nphase;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        cv;
    logic        cr;
    logic [15:0] cdiv;
    logic [4:0]  cdead;
    logic [14:0] coff;
    logic        cd;
    logic        so;
    logic [2:0]  co;

    int checks = 0;
    int errors = 0;
    int high0  = 0;

    mod_clkgen_nphase #(
        .NUM_CH   (3),
        .DIV_W    (16),
        .PHASE_W  (5),
        .DEF_DIV  (0),
        .DEF_DEAD (1)
    ) dut (
        .USER_CLOCK (clk),
        .RESET      (rst),
        .ENABLE     (en),
        .CFG_VALID  (cv),
        .CFG_READY  (cr),
        .CFG_DIV    (cdiv),
        .CFG_DEAD   (cdead),
        .CFG_OFFSET (coff),
        .CFG_DONE   (cd),
        .SYNC_OUT   (so),
        .CLK_OUT    (co)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just after the rising edge.
    task automatic step_clk;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Hand-derived windows for dead=2, offsets {0,16,8}:
    // ch0 steps 2..15, ch1 steps 18..31, ch2 steps 10..23.
    function automatic logic [2:0] exp_a(input int s);
        exp_a = {(s >= 10 && s <= 23), (s >= 18 && s <= 31), (s >= 2 && s <= 15)};
    endfunction

    initial begin
        rst = 1'b1; en = 1'b0; cv = 1'b0;
        cdiv = '0; cdead = '0; coff = '0;

        // Reset state
        step_clk;
        step_clk;
        check("rst_clk_out", 32'(co), 32'(0));
        check("rst_sync",    32'(so), 32'(0));
        check("rst_done",    32'(cd), 32'(0));
        check("rst_ready",   32'(cr), 32'(1));
        rst = 1'b0;
        step_clk;
        check("idle_clk_out", 32'(co), 32'(0));

        // Configuration div=0 dead=2 offsets {0,16,8}, then run
        cv = 1'b1; cdiv = 16'd0; cdead = 5'd2; coff = {5'd8, 5'd16, 5'd0};
        step_clk;
        cv = 1'b0;
        check("t1_pend_ready", 32'(cr), 32'(0));
        check("t1_idle_done",  32'(cd), 32'(0));
        step_clk;
        check("t1_idle_keeps_pending", 32'(cr), 32'(0));
        en = 1'b1;
        step_clk;
        check("t1_done_on_start", 32'(cd), 32'(1));
        check("t1_ready_applied", 32'(cr), 32'(1));
        check("t1_clk_out_start", 32'(co), 32'(0));
        for (int c = 1; c <= 32; c++) begin
            step_clk;
            check("t1_clk_out", 32'(co), 32'(exp_a(c - 1)));
            check("t1_overlap", 32'(co[0] & co[1]), 32'(0));
            check("t1_sync",    32'(so), 32'(c == 32));
            check("t1_done",    32'(cd), 32'(0));
        end

        // Mid-period offer of div=3; a second offer while pending is ignored
        for (int c = 1; c <= 32; c++) begin
            step_clk;
            check("t3_clk_out", 32'(co), 32'(exp_a(c - 1)));
            check("t3_ready",   32'(cr), 32'((c <= 5) || (c == 32)));
            check("t3_done",    32'(cd), 32'(c == 32));
            check("t3_sync",    32'(so), 32'(c == 32));
            if (c == 5) begin
                cv = 1'b1; cdiv = 16'd3; cdead = 5'd2; coff = {5'd8, 5'd16, 5'd0};
            end else if (c == 6) begin
                cv = 1'b1; cdiv = 16'd0; cdead = 5'd16; coff = '0;
            end else begin
                cv = 1'b0;
            end
        end

        // div=3: one step per 4 cycles, 128-cycle period
        for (int c = 1; c <= 128; c++) begin
            step_clk;
            check("t2_clk_out", 32'(co), 32'(exp_a((c - 1) >> 2)));
            check("t2_overlap", 32'(co[0] & co[1]), 32'(0));
            check("t2_sync",    32'(so), 32'(c == 128));
            check("t2_done",    32'(cd), 32'(0));
            high0 += int'(co[0]);
        end
        check("t2_ch0_width", 32'(high0), 32'(56));

        // ENABLE dropped at step 5: period completes, then IDLE
        for (int c = 1; c <= 128; c++) begin
            step_clk;
            check("t4_clk_out", 32'(co), 32'(exp_a((c - 1) >> 2)));
            check("t4_sync",    32'(so), 32'(c == 128));
            if (c == 20) begin
                en = 1'b0;
            end
        end
        for (int c = 1; c <= 8; c++) begin
            step_clk;
            check("t4_idle_clk_out", 32'(co), 32'(0));
            check("t4_idle_sync",    32'(so), 32'(0));
        end

        // dead=16: outputs stay low, sync keeps pulsing
        cv = 1'b1; cdiv = 16'd0; cdead = 5'd16; coff = '0;
        step_clk;
        cv = 1'b0;
        check("t5_pend_ready", 32'(cr), 32'(0));
        check("t5_idle_done",  32'(cd), 32'(0));
        step_clk;
        check("t5_idle_keeps_pending", 32'(cr), 32'(0));
        en = 1'b1;
        step_clk;
        check("t5_done_on_start", 32'(cd), 32'(1));
        check("t5_ready",         32'(cr), 32'(1));
        cv = 1'b1; cdiv = 16'd0; cdead = 5'd3; coff = '0;
        for (int c = 1; c <= 32; c++) begin
            step_clk;
            cv = 1'b0;
            check("t5_clk_out", 32'(co), 32'(0));
            check("t5_sync",    32'(so), 32'(c == 32));
            check("t5_done",    32'(cd), 32'(c == 32));
            check("t5_ready",   32'(cr), 32'(c == 32));
        end

        // dead=3, offsets 0: reset at step 12 with a configuration pending
        for (int c = 1; c <= 12; c++) begin
            step_clk;
            check("t6_clk_out", 32'(co), 32'(((c - 1) >= 3) ? 3'b111 : 3'b000));
            check("t6_ready",   32'(cr), 32'(c <= 6));
            if (c == 6) begin
                cv = 1'b1; cdiv = 16'd5; cdead = 5'd7;
            end else begin
                cv = 1'b0;
            end
        end
        rst = 1'b1;
        step_clk;
        check("t6_rst_clk_out", 32'(co), 32'(0));
        check("t6_rst_ready",   32'(cr), 32'(1));
        check("t6_rst_sync",    32'(so), 32'(0));
        check("t6_rst_done",    32'(cd), 32'(0));
        rst = 1'b0;
        step_clk;
        check("t6_start_no_done", 32'(cd), 32'(0));
        check("t6_start_ready",   32'(cr), 32'(1));
        check("t6_start_clk_out", 32'(co), 32'(0));
        // Defaults div=0 dead=1 offsets 0: high for steps 1..15
        for (int c = 1; c <= 32; c++) begin
            step_clk;
            check("t6_def_clk_out", 32'(co), 32'((((c - 1) >= 1) && ((c - 1) <= 15)) ? 3'b111 : 3'b000));
            check("t6_def_sync",    32'(so), 32'(c == 32));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mod_clkgen_nphase.md
MOD_CLKGEN_NPHASE -- requirements
Module: mod_clkgen_nphase

Interface
REQ-001 SHALL have parameter NUM_CH, default 3: number of modulation clock channels.
REQ-002 SHALL have parameter DIV_W, default 16: prescaler divide-value width.
REQ-003 SHALL have parameter PHASE_W, default 5: step-counter width; STEPS = 2**PHASE_W steps per output period.
REQ-004 SHALL have parameter DEF_DIV, default 0: prescaler divide value loaded at reset.
REQ-005 SHALL have parameter DEF_DEAD, default 1: dead-time steps loaded at reset.
REQ-006 SHALL have port USER_CLOCK  in  1: the single clock; all logic on its rising edge.
REQ-007 SHALL have port RESET  in  1: synchronous, active-high reset.
REQ-008 SHALL have port ENABLE  in  1: run request.
REQ-009 SHALL have port CFG_VALID  in  1: new configuration offered.
REQ-010 SHALL have port CFG_READY  out  1: high when no configuration is pending.
REQ-011 SHALL have port CFG_DIV  in  DIV_W: prescaler divide value; tick period = CFG_DIV+1 cycles.
REQ-012 SHALL have port CFG_DEAD  in  PHASE_W: dead time, in steps.
REQ-013 SHALL have port CFG_OFFSET  in  NUM_CH*PHASE_W: per-channel phase offset; channel k uses bits [k*PHASE_W +: PHASE_W].
REQ-014 SHALL have port CFG_DONE  out  1: one-cycle pulse when a pending configuration becomes active.
REQ-015 SHALL have port SYNC_OUT  out  1: one-cycle pulse at every period boundary.
REQ-016 SHALL have port CLK_OUT  out  NUM_CH: registered modulation clocks.

Function
REQ-017 SHALL hold an active configuration (div, dead, offsets) and a pending configuration with a pending flag.
REQ-018 SHALL drive CFG_READY = ~pending; CFG_VALID && CFG_READY captures all CFG_* inputs into pending and sets the flag; CFG_VALID while CFG_READY is low is ignored.
REQ-019 SHALL implement FSM states IDLE and RUN.
- IDLE: prescaler = 0, step = 0, CLK_OUT = 0.
- IDLE->RUN on ENABLE=1.
- RUN->IDLE only at a period boundary with ENABLE=0. ENABLE low mid-period completes the period.
REQ-020 SHALL, in RUN, count the prescaler 0..div and assert tick when prescaler == div; the prescaler wraps to 0 on tick.
REQ-021 SHALL advance step on each tick, modulo STEPS; period boundary = tick && step == STEPS-1.
REQ-022 SHALL apply a pending configuration and pulse CFG_DONE in the same cycle on either of: (a) a period boundary, or (b) the IDLE->RUN transition. The flag clears in that cycle and new values govern the next step.
REQ-023 SHALL, when a pending configuration is applied while IDLE remains IDLE (ENABLE=0), keep it pending. Configuration never changes mid-period, so no runt pulses on div/offset changes.
REQ-024 SHALL, for each cycle in RUN, compute rel_k = (step - offset_k) mod STEPS (PHASE_W-bit wrap) and register CLK_OUT[k] = 1 iff dead <= rel_k < STEPS/2. One-cycle latency from step to CLK_OUT.
REQ-025 SHALL force CLK_OUT[k] to 0 for the whole period when dead >= STEPS/2.
REQ-026 SHALL guarantee channels with offsets differing by STEPS/2 and dead >= 1 are never simultaneously high.
REQ-027 SHALL register SYNC_OUT, high the cycle after each period boundary.
REQ-028 SHALL, on simultaneous accept (CFG_VALID&&CFG_READY) and apply in one cycle, apply the old pending value; the flag stays set holding the new value.

Reset
REQ-029 SHALL, while RESET=1:
- FSM -> IDLE; prescaler, step, pending flag, CLK_OUT, SYNC_OUT, CFG_DONE -> 0; CFG_READY -> 1.
- active div = DEF_DIV, dead = DEF_DEAD, all offsets = 0.
REQ-030 SHALL make reset mid-period abort immediately (CLK_OUT 0 the next cycle) and discard any pending configuration.

Verification (NUM_CH=3, PHASE_W=5, STEPS=32)
REQ-031 SHALL check: reset, config div=0/dead=2/offsets{0,16,8}, ENABLE=1 -> CFG_DONE on RUN entry; period 32 cycles. CLK_OUT[0] high 14 cycles (steps 2..15), CLK_OUT[1] steps 18..31, CLK_OUT[2] steps 10..23; [0] and [1] never overlap.
REQ-032 SHALL check: div=3 -> step advances every 4 cycles; period 128 cycles; SYNC_OUT every 128 cycles.
REQ-033 SHALL check: new config offered mid-period -> CFG_READY low until the boundary. CFG_DONE at the boundary; no CLK_OUT pulse shorter than (dead-free width) across the switch. Second CFG_VALID while pending is ignored.
REQ-034 SHALL check: ENABLE dropped at step 5 -> outputs continue to step 31; IDLE after the boundary; CLK_OUT = 0.
REQ-035 SHALL check: dead=16 -> all CLK_OUT stay 0 while SYNC_OUT still pulses every period.
REQ-036 SHALL check: RESET asserted at step 12 with config pending -> CLK_OUT = 0 and CFG_READY = 1 the next cycle; active div/dead return to DEF_DIV/DEF_DEAD.
